// File: rtl/debug_unit_pkg.sv
// Shared definitions for the CPU run-control/display debugger.
package debug_unit_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [3:0] SEL_CP   = 4'd0;
  localparam logic [3:0] SEL_IND  = 4'd1;
  localparam logic [3:0] SEL_AM   = 4'd2;
  localparam logic [3:0] SEL_AIE  = 4'd3;
  localparam logic [3:0] SEL_T1   = 4'd4;
  localparam logic [3:0] SEL_T2   = 4'd5;
  localparam logic [3:0] SEL_RI   = 4'd6;
  localparam logic [3:0] SEL_BUS  = 4'd7;
  localparam logic [3:0] SEL_RAM  = 4'd8;
  localparam logic [3:0] SEL_REGS = 4'd9;
  localparam logic [3:0] SEL_MAX  = SEL_REGS;

  localparam int NUM_BTN = 3;

  // Segments packed {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

endpackage

// File: rtl/debug_unit_debouncer.sv
// Button conditioner: 2-FF sync, stability counter, one-cycle pulse on accepted press.
module debug_unit_debouncer #(
  parameter int p_width = 16
) (
  input  logic i_w_clk,
  input  logic i_w_reset,
  input  logic i_w_raw,
  output logic o_w_pulse
);

  logic [1:0]         sync;
  logic               stable;
  logic [p_width-1:0] cnt;

  // A new level is accepted only after 2^p_width consecutive samples disagree with the old one.
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      sync      <= '0;
      stable    <= 1'b0;
      cnt       <= '0;
      o_w_pulse <= 1'b0;
    end else begin
      sync      <= {sync[0], i_w_raw};
      o_w_pulse <= 1'b0;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (&cnt) begin
        stable    <= sync[1];
        cnt       <= '0;
        o_w_pulse <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/debug_unit.sv
// Run-control (halt/step/run/breakpoint) and 7-segment value display for the microprogrammed CPU.
import debug_unit_pkg::*;

module debug_unit #(
  parameter int p_data_width     = 16,
  parameter int p_address_width  = 10,
  parameter int p_debounce_width = 16,
  parameter int p_scan_width     = 16
) (
  input  logic                       i_w_clk,
  input  logic                       i_w_reset,
  input  logic                       i_w_btn_step,
  input  logic                       i_w_btn_run,
  input  logic                       i_w_btn_next,
  input  logic                       i_w_sw_micro,
  input  logic                       i_w_sw_bp_en,
  input  logic [p_address_width-1:0] i_w_bp_addr,
  input  logic [p_address_width-1:0] i_w_disp_addr,
  input  logic                       i_w_fetch,
  input  logic [p_data_width-1:0]    i_w_cp,
  input  logic [p_data_width-1:0]    i_w_ind,
  input  logic [p_data_width-1:0]    i_w_am,
  input  logic [p_data_width-1:0]    i_w_aie,
  input  logic [p_data_width-1:0]    i_w_t1,
  input  logic [p_data_width-1:0]    i_w_t2,
  input  logic [p_data_width-1:0]    i_w_ri,
  input  logic [p_data_width-1:0]    i_w_bus,
  input  logic [p_data_width-1:0]    i_w_ram,
  input  logic [p_data_width-1:0]    i_w_regs,
  output logic                       o_w_cpu_en,
  output logic                       o_w_halted,
  output logic                       o_w_bp_hit,
  output logic [3:0]                 o_w_sel,
  output logic [p_address_width-1:0] o_w_ram_disp_addr,
  output logic [2:0]                 o_w_regs_disp_addr,
  output logic [6:0]                 o_w_seg,
  output logic [3:0]                 o_w_an
);

  // ---------------- buttons ----------------
  logic [NUM_BTN-1:0] btn_raw, btn_p;
  logic               step_p, run_p, next_p;

  assign btn_raw = {i_w_btn_next, i_w_btn_run, i_w_btn_step};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    debug_unit_debouncer #(.p_width(p_debounce_width)) u_db (
      .i_w_clk   (i_w_clk),
      .i_w_reset (i_w_reset),
      .i_w_raw   (btn_raw[g]),
      .o_w_pulse (btn_p[g])
    );
  end

  assign step_p = btn_p[0];
  assign run_p  = btn_p[1];
  assign next_p = btn_p[2];

  // ---------------- run control ----------------
  state_e state, state_nx;
  logic   first, en, bp_set, bp_clr, bp_match;

  assign bp_match = !first && i_w_sw_bp_en && i_w_fetch &&
                    (i_w_cp[p_address_width-1:0] == i_w_bp_addr);

  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      state      <= ST_HALT;
      first      <= 1'b0;
      o_w_bp_hit <= 1'b0;
    end else begin
      state <= state_nx;
      first <= (state == ST_HALT) && (state_nx != ST_HALT);
      if (bp_clr)      o_w_bp_hit <= 1'b0;
      else if (bp_set) o_w_bp_hit <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    en       = 1'b0;
    bp_set   = 1'b0;
    bp_clr   = 1'b0;
    case (state)
      ST_HALT: begin
        if (step_p) begin
          state_nx = ST_STEP;
          bp_clr   = 1'b1;
        end else if (run_p) begin
          state_nx = ST_RUN;
          bp_clr   = 1'b1;
        end
      end
      ST_STEP: begin
        // Instruction step runs until the next fetch, freezing the CPU at that boundary.
        if (i_w_sw_micro) begin
          en       = 1'b1;
          state_nx = ST_HALT;
        end else if (first || !i_w_fetch) begin
          en = 1'b1;
        end else begin
          state_nx = ST_HALT;
        end
      end
      ST_RUN: begin
        if (bp_match) begin
          state_nx = ST_HALT;
          bp_set   = 1'b1;
        end else begin
          en = 1'b1;
          if (run_p) state_nx = ST_HALT;
        end
      end
      default: state_nx = ST_HALT;
    endcase
  end

  assign o_w_cpu_en = en && !i_w_reset;
  assign o_w_halted = (state == ST_HALT);

  // ---------------- display select ----------------
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      o_w_sel            <= SEL_CP;
      o_w_ram_disp_addr  <= '0;
      o_w_regs_disp_addr <= '0;
    end else begin
      if (next_p) o_w_sel <= (o_w_sel == SEL_MAX) ? SEL_CP : o_w_sel + 4'd1;
      o_w_ram_disp_addr  <= i_w_disp_addr;
      o_w_regs_disp_addr <= i_w_disp_addr[2:0];
    end
  end

  logic [p_data_width-1:0] disp_mux, disp_val;

  always_comb begin
    disp_mux = '0;
    case (o_w_sel)
      SEL_CP:   disp_mux = i_w_cp;
      SEL_IND:  disp_mux = i_w_ind;
      SEL_AM:   disp_mux = i_w_am;
      SEL_AIE:  disp_mux = i_w_aie;
      SEL_T1:   disp_mux = i_w_t1;
      SEL_T2:   disp_mux = i_w_t2;
      SEL_RI:   disp_mux = i_w_ri;
      SEL_BUS:  disp_mux = i_w_bus;
      SEL_RAM:  disp_mux = i_w_ram;
      SEL_REGS: disp_mux = i_w_regs;
      default:  disp_mux = '0;
    endcase
  end

  // ---------------- scan ----------------
  logic [p_scan_width-1:0] scan_cnt;
  logic [1:0]              digit;
  logic [3:0]              nib;

  assign digit = scan_cnt[p_scan_width-1 -: 2];
  assign nib   = disp_val[{digit, 2'b00} +: 4];

  // Anodes and segments are registered together so a digit never shows its neighbour's value.
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      disp_val <= '0;
      scan_cnt <= '0;
      o_w_an   <= 4'b1111;
      o_w_seg  <= 7'h7F;
    end else begin
      disp_val <= disp_mux;
      scan_cnt <= scan_cnt + 1'b1;
      o_w_an   <= ~(4'b0001 << digit);
      o_w_seg  <= hex7(nib);
    end
  end

endmodule
